// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: program counter, ROM address/enable generation and
// the IF/ID pipeline register feeding decode, with delay-slot branch redirect.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_INST = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if_i,
  input  logic        stall_id_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_adel_o
);

  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        bubble;

  // A branch seen while IF is stalled is dropped; decode re-asserts it later.
  always_comb begin
    next_pc = pc + 32'd4;
    if (flush_i)
      next_pc = new_pc_i;
    else if (stall_if_i)
      next_pc = pc;
    else if (branch_flag_i)
      next_pc = branch_target_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_ce_o <= 1'b0;
      pc       <= RESET_PC;
    end else begin
      rom_ce_o <= 1'b1;
      if (rom_ce_o)
        pc <= next_pc;
    end
  end

  assign rom_addr_o = pc;

  assign bubble = !rom_ce_o || flush_i || (stall_if_i && !stall_id_i);

  // Misaligned fetches pass through with adel set so decode can raise AdEL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc_o   <= 32'h00000000;
      id_inst_o <= NOP_INST;
      id_adel_o <= 1'b0;
    end else if (bubble) begin
      id_pc_o   <= 32'h00000000;
      id_inst_o <= NOP_INST;
      id_adel_o <= 1'b0;
    end else if (!stall_id_i) begin
      id_pc_o   <= pc;
      id_inst_o <= rom_data_i;
      id_adel_o <= (pc[1:0] != 2'b00);
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed scoreboard bench for pc_fetch_stage: expected outputs are queued
// per step and compared one cycle later, just after the rising edge.
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if_i, stall_id_i, branch_flag_i, flush_i;
  logic [31:0] branch_target_i, new_pc_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o, rom_data_i, id_pc_o, id_inst_o;
  logic        id_adel_o;

  typedef struct {
    string       tag;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] idpc;
    logic [31:0] idinst;
    logic        adel;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pc_fetch_stage dut (
    .clk(clk), .rst(rst),
    .stall_if_i(stall_if_i), .stall_id_i(stall_id_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .flush_i(flush_i), .new_pc_i(new_pc_i),
    .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_adel_o(id_adel_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h34010001;
    return {16'hC0DE, a[15:0]};
  endfunction

  assign rom_data_i = rom_word(rom_addr_o);

  task automatic push_exp(input string tag, input logic ce, input logic [31:0] addr,
                          input logic [31:0] idpc, input logic [31:0] idinst,
                          input logic adel);
    exp_t e;
    e.tag = tag; e.ce = ce; e.addr = addr; e.idpc = idpc; e.idinst = idinst; e.adel = adel;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_empty: got queue size 0, required 1");
      return;
    end
    e = exp_q.pop_front();
    checks++;
    assert (rom_ce_o === e.ce) else begin
      errors++;
      $error("[TB] FAIL %s rom_ce_o: got %b, required %b", e.tag, rom_ce_o, e.ce);
    end
    checks++;
    assert (rom_addr_o === e.addr) else begin
      errors++;
      $error("[TB] FAIL %s rom_addr_o: got %h, required %h", e.tag, rom_addr_o, e.addr);
    end
    checks++;
    assert (id_pc_o === e.idpc) else begin
      errors++;
      $error("[TB] FAIL %s id_pc_o: got %h, required %h", e.tag, id_pc_o, e.idpc);
    end
    checks++;
    assert (id_inst_o === e.idinst) else begin
      errors++;
      $error("[TB] FAIL %s id_inst_o: got %h, required %h", e.tag, id_inst_o, e.idinst);
    end
    checks++;
    assert (id_adel_o === e.adel) else begin
      errors++;
      $error("[TB] FAIL %s id_adel_o: got %b, required %b", e.tag, id_adel_o, e.adel);
    end
  endtask

  // Drive one cycle of controls, queue what must appear after the edge, check it.
  task automatic applyStimulus(input string tag, input logic sif, input logic sid,
                               input logic br, input logic [31:0] tgt,
                               input logic fl, input logic [31:0] npc,
                               input logic ce, input logic [31:0] addr,
                               input logic [31:0] idpc, input logic [31:0] idinst,
                               input logic adel);
    stall_if_i = sif; stall_id_i = sid; branch_flag_i = br; branch_target_i = tgt;
    flush_i = fl; new_pc_i = npc;
    push_exp(tag, ce, addr, idpc, idinst, adel);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    rst = 1'b0;
    stall_if_i = 0; stall_id_i = 0; branch_flag_i = 0; flush_i = 0;
    branch_target_i = 0; new_pc_i = 0;
    repeat (10) @(posedge clk);
    #1;
    push_exp("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    checkOutput();
    rst = 1'b1;

    applyStimulus("ramp",     0,0,0,32'h0, 0,32'h0, 1, 32'h00, 32'h00, 32'h0, 0);
    applyStimulus("fetch0",   0,0,0,32'h0, 0,32'h0, 1, 32'h04, 32'h00, 32'h34010001, 0);
    applyStimulus("fetch4",   0,0,0,32'h0, 0,32'h0, 1, 32'h08, 32'h04, rom_word(32'h04), 0);
    applyStimulus("jump_ds",  0,0,1,32'h2C,0,32'h0, 1, 32'h2C, 32'h08, rom_word(32'h08), 0);
    applyStimulus("jump_tgt", 0,0,0,32'h0, 0,32'h0, 1, 32'h30, 32'h2C, rom_word(32'h2C), 0);
    applyStimulus("br_to10",  0,0,1,32'h10,0,32'h0, 1, 32'h10, 32'h30, rom_word(32'h30), 0);
    applyStimulus("stall_a",  1,1,0,32'h0, 0,32'h0, 1, 32'h10, 32'h30, rom_word(32'h30), 0);
    applyStimulus("stall_b",  1,1,0,32'h0, 0,32'h0, 1, 32'h10, 32'h30, rom_word(32'h30), 0);
    applyStimulus("if_bubble",1,0,0,32'h0, 0,32'h0, 1, 32'h10, 32'h00, 32'h0, 0);
    applyStimulus("resume",   0,0,0,32'h0, 0,32'h0, 1, 32'h14, 32'h10, rom_word(32'h10), 0);
    applyStimulus("flush_br", 0,0,1,32'h40,1,32'h20,1, 32'h20, 32'h00, 32'h0, 0);
    applyStimulus("post_fl",  0,0,0,32'h0, 0,32'h0, 1, 32'h24, 32'h20, rom_word(32'h20), 0);
    applyStimulus("br_mis",   0,0,1,32'h2E,0,32'h0, 1, 32'h2E, 32'h24, rom_word(32'h24), 0);
    applyStimulus("adel_2e",  0,0,0,32'h0, 0,32'h0, 1, 32'h32, 32'h2E, rom_word(32'h2E), 1);
    applyStimulus("adel_32",  0,0,0,32'h0, 0,32'h0, 1, 32'h36, 32'h32, rom_word(32'h32), 1);
    applyStimulus("fl_top",   0,0,0,32'h0, 1,32'hFFFFFFFC, 1, 32'hFFFFFFFC, 32'h0, 32'h0, 0);
    applyStimulus("wrap",     0,0,0,32'h0, 0,32'h0, 1, 32'h00, 32'hFFFFFFFC, rom_word(32'hFFFFFFFC), 0);
    applyStimulus("after_wrap",0,0,0,32'h0,0,32'h0, 1, 32'h04, 32'h00, 32'h34010001, 0);
    applyStimulus("br_stalled",1,1,1,32'h80,0,32'h0,1, 32'h04, 32'h00, 32'h34010001, 0);
    applyStimulus("br_dropped",0,0,0,32'h0,0,32'h0, 1, 32'h08, 32'h04, rom_word(32'h04), 0);
    applyStimulus("id_stall", 0,1,0,32'h0, 0,32'h0, 1, 32'h0C, 32'h04, rom_word(32'h04), 0);
    applyStimulus("id_resume",0,0,0,32'h0, 0,32'h0, 1, 32'h10, 32'h0C, rom_word(32'h0C), 0);
    applyStimulus("br_to24",  0,0,1,32'h24,0,32'h0, 1, 32'h24, 32'h10, rom_word(32'h10), 0);

    // Asynchronous reset between edges, checked before any further edge.
    branch_flag_i = 0;
    #2;
    rst = 1'b0;
    #1;
    push_exp("async_rst", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    checkOutput();
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus("ramp2",    0,0,0,32'h0, 0,32'h0, 1, 32'h00, 32'h00, 32'h0, 0);
    applyStimulus("fetch0_2", 0,0,0,32'h0, 0,32'h0, 1, 32'h04, 32'h00, 32'h34010001, 0);

    $display("[TB] stimulus complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
